// File: rtl/io_port_pkg.sv
// Shared constants for the register-mapped I/O port bank: CTRL page layout,
// page-select bit helper and the post-reset prime count.
package io_port_pkg;

   localparam int CHG_IDX      = 0;
   localparam int MASK_IDX     = 1;
   localparam int PRIME_CYCLES = 3;

   // The page-select bit sits directly above the port index field.
   function automatic int page_bit(input int nports);
      return $clog2(nports);
   endfunction

endpackage

// File: rtl/io_port_in_sync.sv
// Per-port input path: 2-flop synchroniser, previous-value register and a sticky
// change flag where a new change beats a same-cycle read-clear.
module io_port_in_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             detect_en,
   input  logic             clr,
   output logic [WIDTH-1:0] dout,
   output logic             chg
);

   logic [WIDTH-1:0] sync1, sync2, prev;
   logic             set;

   assign set  = detect_en && (sync2 != prev);
   assign dout = sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         chg   <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
         chg   <= set | (chg & ~clr);
      end
   end

endmodule

// File: rtl/io_port_bank.sv
// NPORTS x WIDTH input/output port bank with synchronised inputs, sticky change
// flags, output write strobes. Optional change interrupt: IO_PORT_BANK_IRQ_EN.
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = $clog2(NPORTS) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic                     cpu_we,
   input  logic                     cpu_re,
   input  logic [WIDTH-1:0]         cpu_wdata,
   output logic [WIDTH-1:0]         cpu_rdata,
   output logic                     cpu_rvalid,
   input  logic [NPORTS*WIDTH-1:0]  port_in,
   output logic [NPORTS*WIDTH-1:0]  port_out,
   output logic [NPORTS-1:0]        port_out_stb,
   output logic                     irq
);

   localparam int PG = page_bit(NPORTS);
   localparam int IW = ADDR_W - 1;

   logic                          page_ctrl;
   logic [IW-1:0]                 idx;
   logic                          idx_ok;
   logic [NPORTS-1:0][WIDTH-1:0]  din_s;
   logic [NPORTS-1:0][WIDTH-1:0]  out_q;
   logic [NPORTS-1:0]             chg, clr, wr_hit;
   logic [NPORTS-1:0]             mask_rd;
   logic [WIDTH-1:0]              rd_mux;
   logic [1:0]                    prime_cnt;
   logic                          detect_en;

   assign page_ctrl = cpu_addr[PG];
   assign idx       = cpu_addr[IW-1:0];
   assign idx_ok    = ADDR_W'(idx) < ADDR_W'(NPORTS);
   assign detect_en = prime_cnt == 2'(PRIME_CYCLES);
   assign port_out  = out_q;

   for (genvar i = 0; i < NPORTS; i++) begin : g_in
      io_port_in_sync #(.WIDTH(WIDTH)) u_sync (
         .clk       (clk),
         .reset     (reset),
         .din       (port_in[i*WIDTH +: WIDTH]),
         .detect_en (detect_en),
         .clr       (clr[i]),
         .dout      (din_s[i]),
         .chg       (chg[i])
      );
   end

   always_comb begin
      clr    = '0;
      wr_hit = '0;
      for (int i = 0; i < NPORTS; i++) begin
         clr[i]    = cpu_re && !page_ctrl && (idx == IW'(i));
         wr_hit[i] = cpu_we && !page_ctrl && (idx == IW'(i));
      end
   end

   always_comb begin
      rd_mux = '0;
      if (!page_ctrl) begin
         if (idx_ok) rd_mux = din_s[idx];
      end else if (idx == IW'(CHG_IDX)) begin
         rd_mux = WIDTH'(chg);
      end else if (idx == IW'(MASK_IDX)) begin
         rd_mux = WIDTH'(mask_rd);
      end
   end

   // rdata holds its last value between reads; only rvalid pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_re;
         if (cpu_re) cpu_rdata <= rd_mux;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q        <= '0;
         port_out_stb <= '0;
      end else begin
         port_out_stb <= wr_hit;
         for (int i = 0; i < NPORTS; i++)
            if (wr_hit[i]) out_q[i] <= cpu_wdata;
      end
   end

   // Holds change detection off until the synchronisers have filled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prime_cnt <= '0;
      else if (!detect_en)
         prime_cnt <= prime_cnt + 2'd1;
   end

`ifdef IO_PORT_BANK_IRQ_EN
   logic [NPORTS-1:0] mask_q;
   logic              irq_q;

   assign mask_rd = mask_q;
   assign irq     = irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (cpu_we && page_ctrl && (idx == IW'(MASK_IDX)))
            mask_q <= cpu_wdata[NPORTS-1:0];
         irq_q <= |(chg & mask_q);
      end
   end
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (NPORTS=4, WIDTH=8).
module tb_io_port_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cpu_addr;
   logic        cpu_we, cpu_re;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_rvalid;
   logic [31:0] port_in;
   logic [31:0] port_out;
   logic [3:0]  port_out_stb;
   logic        irq;

   int checks = 0;
   int errors = 0;

   io_port_bank #(.NPORTS(4), .WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_we       (cpu_we),
      .cpu_re       (cpu_re),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_rvalid   (cpu_rvalid),
      .port_in      (port_in),
      .port_out     (port_out),
      .port_out_stb (port_out_stb),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; cpu_addr = '0; cpu_we = 0; cpu_re = 0; cpu_wdata = '0;
      port_in = 32'h0000_005A;
      tick(3);
      checks++;
      if (port_out !== 32'h0 || port_out_stb !== 4'h0 || cpu_rvalid !== 1'b0 ||
          cpu_rdata !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: out=%h stb=%b rv=%b rd=%h irq=%b want all 0",
                  port_out, port_out_stb, cpu_rvalid, cpu_rdata, irq);
      end
      reset = 1'b1;
      tick(4);
      cpu_re = 1; cpu_addr = 3'd0;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
         errors++;
         $display("FAIL reset_data0: rv=%b rd=%h want rv=1 rd=5a", cpu_rvalid, cpu_rdata);
      end
      cpu_re = 1; cpu_addr = 3'b100;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_no_spurious_chg: rd=%h want 00", cpu_rdata);
      end
      // reset landing on a pending read valid
      cpu_re = 1; cpu_addr = 3'd0;
      tick();
      cpu_re = 0;
      reset = 1'b0;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_read: rv=%b rd=%h want rv=0 rd=00", cpu_rvalid, cpu_rdata);
      end
      tick(2);
      reset = 1'b1;
      tick(6);
   endtask

   task automatic test_write();
      cpu_we = 1; cpu_addr = 3'd2; cpu_wdata = 8'hC3;
      tick();
      cpu_we = 0;
      checks++;
      if (port_out !== 32'h00C3_0000 || port_out_stb !== 4'b0100) begin
         errors++;
         $display("FAIL write_data2: out=%h stb=%b want 00c30000 0100", port_out, port_out_stb);
      end
      tick();
      checks++;
      if (port_out_stb !== 4'b0000 || port_out !== 32'h00C3_0000) begin
         errors++;
         $display("FAIL write_stb_one_cycle: out=%h stb=%b want 00c30000 0000", port_out, port_out_stb);
      end
      cpu_we = 1; cpu_addr = 3'b100; cpu_wdata = 8'hAA;
      tick();
      cpu_we = 0;
      checks++;
      if (port_out_stb !== 4'b0000 || port_out !== 32'h00C3_0000) begin
         errors++;
         $display("FAIL write_ctrl_ignored: out=%h stb=%b want 00c30000 0000", port_out, port_out_stb);
      end
      cpu_we = 1; cpu_addr = 3'd2; cpu_wdata = 8'hC3;
      tick();
      cpu_we = 0;
      checks++;
      if (port_out_stb !== 4'b0100) begin
         errors++;
         $display("FAIL write_same_data_stb: stb=%b want 0100", port_out_stb);
      end
      tick();
   endtask

   task automatic test_change();
      port_in[31:24] = 8'h10;
      tick(2);
      // captured on the same edge that sets the flag, so still clear
      cpu_re = 1; cpu_addr = 3'b100;
      tick();
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL chg_latency_early: rd=%h want 00", cpu_rdata);
      end
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h08 || cpu_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL chg_port3_set: rd=%h rv=%b want 08 1", cpu_rdata, cpu_rvalid);
      end
      cpu_re = 1; cpu_addr = 3'd3;
      tick();
      checks++;
      if (cpu_rdata !== 8'h10) begin
         errors++;
         $display("FAIL chg_data3: rd=%h want 10", cpu_rdata);
      end
      cpu_addr = 3'b100;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL chg_read_clear: rd=%h want 00", cpu_rdata);
      end
   endtask

   task automatic test_set_wins();
      port_in[15:8] = 8'h3C;
      tick(2);
      cpu_re = 1; cpu_addr = 3'd1;
      tick();
      checks++;
      if (cpu_rdata !== 8'h3C) begin
         errors++;
         $display("FAIL setwins_data1: rd=%h want 3c", cpu_rdata);
      end
      cpu_addr = 3'b100;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h02) begin
         errors++;
         $display("FAIL setwins_chg1: rd=%h want 02", cpu_rdata);
      end
      cpu_re = 1; cpu_addr = 3'd1;
      tick();
      cpu_addr = 3'b100;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL setwins_later_clear: rd=%h want 00", cpu_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [5];
      logic [2:0] adr [5];
      exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      adr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'b111};
      port_in = 32'h4433_2211;
      tick(4);
      cpu_re = 1;
      for (int k = 0; k < 5; k++) begin
         cpu_addr = adr[k];
         tick();
         checks++;
         if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp[k]) begin
            errors++;
            $display("FAIL b2b_read%0d: rv=%b rd=%h want 1 %h", k, cpu_rvalid, cpu_rdata, exp[k]);
         end
      end
      cpu_re = 0;
      tick();
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL b2b_idle_hold: rv=%b rd=%h want 0 00", cpu_rvalid, cpu_rdata);
      end
      cpu_re = 1; cpu_addr = 3'b100;
      tick();
      cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL b2b_all_cleared: rd=%h want 00", cpu_rdata);
      end
   endtask

   task automatic test_rw_same_cycle();
      cpu_we = 1; cpu_re = 1; cpu_addr = 3'd0; cpu_wdata = 8'h77;
      tick();
      cpu_we = 0; cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h11 || port_out[7:0] !== 8'h77 || port_out_stb !== 4'b0001) begin
         errors++;
         $display("FAIL rw_same_cycle: rd=%h out0=%h stb=%b want 11 77 0001",
                  cpu_rdata, port_out[7:0], port_out_stb);
      end
      cpu_we = 1; cpu_addr = 3'b101; cpu_wdata = 8'hFF;
      tick();
      cpu_we = 0;
      checks++;
      if (port_out_stb !== 4'b0000) begin
         errors++;
         $display("FAIL mask_write_no_stb: stb=%b want 0000", port_out_stb);
      end
      cpu_re = 1;
      tick();
      cpu_re = 0;
      checks++;
`ifdef IO_PORT_BANK_IRQ_EN
      if (cpu_rdata !== 8'h0F) begin
         errors++;
         $display("FAIL mask_readback: rd=%h want 0f", cpu_rdata);
      end
`else
      if (cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL mask_readback: rd=%h want 00", cpu_rdata);
      end
`endif
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_idle: irq=%b want 0", irq);
      end
   endtask

`ifdef IO_PORT_BANK_IRQ_EN
   task automatic test_irq();
      cpu_we = 1; cpu_re = 1; cpu_addr = 3'b101; cpu_wdata = 8'h02;
      tick();
      cpu_we = 0; cpu_re = 0;
      checks++;
      if (cpu_rdata !== 8'h0F) begin
         errors++;
         $display("FAIL irq_mask_old_value: rd=%h want 0f", cpu_rdata);
      end
      port_in[7:0] = 8'hEE;
      tick(5);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_masked_port0: irq=%b want 0", irq);
      end
      port_in[15:8] = 8'hDD;
      tick(3);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_before_flag: irq=%b want 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise: irq=%b want 1", irq);
      end
      cpu_re = 1; cpu_addr = 3'd1;
      tick();
      cpu_re = 0;
      checks++;
      if (irq !== 1'b1 || cpu_rdata !== 8'hDD) begin
         errors++;
         $display("FAIL irq_hold_on_clear: irq=%b rd=%h want 1 dd", irq, cpu_rdata);
      end
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall: irq=%b want 0", irq);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_change();
      test_set_wins();
      test_back_to_back();
      test_rw_same_cycle();
`ifdef IO_PORT_BANK_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
